// File: rtl/snake_turn_queue.sv
// snake_turn_queue: buffers legal direction presses and commits one per game tick
//   i_Clk, i_Rst_L      clock, asynchronous active-low reset
//   i_Up..i_Right       debounced button levels
//   i_Game_Tick         one-cycle game-rate pulse
//   i_Game_Over         level; flushes the queue and restores INIT_DIR
//   o_Dir, o_Step       committed direction and its one-cycle step strobe
//   o_Queue_Count       pending turns
//   o_Drop              one-cycle pulse when a press is rejected
module snake_turn_queue #(
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [1:0]  INIT_DIR    = 2'b11
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Left,
    input  logic       i_Right,
    input  logic       i_Game_Tick,
    input  logic       i_Game_Over,
    output logic [1:0] o_Dir,
    output logic       o_Step,
    output logic [2:0] o_Queue_Count,
    output logic       o_Drop
);
    localparam logic [1:0] last_idx = 2'(QUEUE_DEPTH - 1);
    logic [1:0] q [4];
    logic [3:0] btn, prev, ev;
    logic [1:0] rd, wr, tail_idx, win, ref_dir;
    logic       multi, pop, full, accept, drop_c;
    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == last_idx) ? 2'd0 : p + 2'd1;
    endfunction
    assign btn      = {i_Up, i_Down, i_Left, i_Right};
    assign ev       = btn & ~prev;
    assign win      = ev[3] ? 2'b00 : ev[2] ? 2'b01 : ev[1] ? 2'b10 : 2'b11;
    // more than one rising edge this cycle: losers are discarded
    assign multi    = |(ev & (ev - 4'd1));
    assign tail_idx = (wr == 2'd0) ? last_idx : wr - 2'd1;
    assign ref_dir  = (o_Queue_Count != 3'd0) ? q[tail_idx] : o_Dir;
    assign pop      = i_Game_Tick && (o_Queue_Count != 3'd0);
    assign full     = o_Queue_Count == 3'(QUEUE_DEPTH);
    // a pop in the same cycle frees the slot, so a full queue may still accept
    assign accept   = (|ev) && (win != ref_dir) && (win != (ref_dir ^ 2'b01)) && (!full || pop);
    assign drop_c   = (|ev) && (multi || !accept);
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            prev          <= '0;
            rd            <= '0;
            wr            <= '0;
            o_Queue_Count <= '0;
            o_Dir         <= INIT_DIR;
            o_Step        <= 1'b0;
            o_Drop        <= 1'b0;
        end else begin
            prev <= btn;
            if (i_Game_Over) begin
                rd            <= '0;
                wr            <= '0;
                o_Queue_Count <= '0;
                o_Dir         <= INIT_DIR;
                o_Step        <= 1'b0;
                o_Drop        <= 1'b0;
            end else begin
                o_Step        <= i_Game_Tick;
                o_Drop        <= drop_c;
                o_Queue_Count <= o_Queue_Count + 3'(accept) - 3'(pop);
                if (pop) begin
                    o_Dir <= q[rd];
                    rd    <= nxt(rd);
                end
                if (accept) wr <= nxt(wr);
            end
        end
    end
    // when full, wr == rd: the head is read out on the same edge it is overwritten
    always_ff @(posedge i_Clk) begin
        if (accept && !i_Game_Over) q[wr] <= win;
    end
endmodule

// File: tb/tb_snake_turn_queue.sv
// tb_snake_turn_queue: randomized scoreboard bench for snake_turn_queue
module tb_snake_turn_queue;
    localparam int         DEPTH = 2;
    localparam logic [1:0] INIT  = 2'b11;
    logic clk = 0, rst_n = 0, up = 0, down = 0, left = 0, right = 0, tick = 0, go = 0;
    logic [1:0] dir;
    logic [2:0] count;
    logic       step, drop;
    typedef struct packed {
        logic [1:0] dir;
        logic       step;
        logic [2:0] count;
        logic       drop;
    } exp_t;
    exp_t       exp_q[$];
    exp_t       me;
    logic [1:0] mq[$];
    logic [1:0] mdir = INIT;
    logic [3:0] mprev = '0;
    int n_checks = 0, n_fail = 0;
    always #5 clk = ~clk;
    snake_turn_queue #(.QUEUE_DEPTH(DEPTH), .INIT_DIR(INIT)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Up(up), .i_Down(down), .i_Left(left), .i_Right(right),
        .i_Game_Tick(tick), .i_Game_Over(go), .o_Dir(dir), .o_Step(step),
        .o_Queue_Count(count), .o_Drop(drop)
    );
    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b00;
            2'b10:   return 2'b11;
            default: return 2'b10;
        endcase
    endfunction
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // one cycle of stimulus; the reference model predicts outputs after the next edge
    task automatic cyc(input logic r, input logic [3:0] b, input logic t, input logic g);
        exp_t       e;
        logic [3:0] ev;
        logic [1:0] w, rf;
        logic       legal, pop;
        int         n;
        @(posedge clk);
        #2;
        rst_n = r;
        {up, down, left, right} = b;
        tick = t;
        go = g;
        e = '0;
        w = '0;
        if (!r) begin
            mq.delete();
            mdir = INIT;
            mprev = '0;
            #1;
            check("async_reset_dir", 8'(dir), 8'(INIT));
            check("async_reset_count", 8'(count), 8'd0);
        end else begin
            ev = b & ~mprev;
            mprev = b;
            if (g) begin
                mq.delete();
                mdir = INIT;
            end else begin
                e.step = t;
                pop = t && mq.size() > 0;
                rf = mq.size() > 0 ? mq[$] : mdir;
                n = 0;
                for (int i = 3; i >= 0; i--)
                    if (ev[i]) begin
                        if (n == 0) w = 2'(3 - i);
                        n++;
                    end
                legal = 0;
                if (n > 0) begin
                    legal = (w != rf) && (w != opposite(rf)) && (mq.size() < DEPTH || pop);
                    e.drop = (n > 1) || !legal;
                end
                if (pop) mdir = mq.pop_front();
                if (legal) mq.push_back(w);
            end
        end
        e.dir = mdir;
        e.count = 3'(mq.size());
        exp_q.push_back(e);
    endtask
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            check("dir", 8'(dir), 8'(me.dir));
            check("step", 8'(step), 8'(me.step));
            check("count", 8'(count), 8'(me.count));
            check("drop", 8'(drop), 8'(me.drop));
        end
    end
    initial begin
        logic [3:0] lv;
        int         go_left;
        repeat (2) cyc(0, 4'h0, 0, 0);
        repeat (2) cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h0, 1, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h8, 0, 0);
        repeat (9) cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h0, 1, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h0, 0, 1);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h2, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h1, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h8, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h2, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h4, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h0, 1, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h0, 1, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h9, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h2, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h4, 1, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h0, 0, 1);
        cyc(1, 4'h8, 1, 1);
        cyc(1, 4'h0, 1, 1);
        cyc(1, 4'h1, 0, 1);
        cyc(1, 4'h1, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h8, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(0, 4'h0, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h0, 1, 0);
        lv = '0;
        go_left = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) == 0) lv[i] = ~lv[i];
            if (go_left > 0) go_left--;
            else if ($urandom_range(0, 80) == 0) go_left = $urandom_range(1, 5);
            cyc($urandom_range(0, 900) != 0, lv, $urandom_range(0, 4) == 0, go_left > 0);
        end
        repeat (3) cyc(1, 4'h0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
